// File: rtl/cnn_mac_pkg.sv
// Shared widths, state encoding, saturation bounds and sign-extension helpers
// for the CNN MAC accumulation stage (optional ReLU: CNN_MAC_RELU_EN).
package cnn_mac_pkg;

  localparam int PROD_W   = 24;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 14;
  localparam int WGT_FRAC = 8;
  localparam int LEN_W    = 8;

  localparam logic signed [ACC_W-1:0] OUT_MAX  = 32'sd8191;
  localparam logic signed [ACC_W-1:0] OUT_MIN  = -32'sd8192;
  localparam logic signed [ACC_W-1:0] RND_HALF = 32'sd1 <<< (WGT_FRAC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } mac_state_t;

  // Bias shares the output format, so it is aligned to product scale on load.
  function automatic logic signed [ACC_W-1:0] bias_to_acc(input logic signed [OUT_W-1:0] b);
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(b);
    return ext <<< WGT_FRAC;
  endfunction

  function automatic logic signed [ACC_W-1:0] prod_to_acc(input logic signed [PROD_W-1:0] p);
    return ACC_W'(p);
  endfunction

endpackage

// File: rtl/cnn_mac_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation from the
// accumulator to the output format; ReLU clamp when CNN_MAC_RELU_EN is defined.
module cnn_mac_round_sat
  import cnn_mac_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] res_o
);

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] sat_v;

  always_comb begin
    biased  = acc_i + RND_HALF;
    shifted = biased >>> WGT_FRAC;
    if (shifted > OUT_MAX) begin
      sat_v = OUT_MAX[OUT_W-1:0];
    end else if (shifted < OUT_MIN) begin
      sat_v = OUT_MIN[OUT_W-1:0];
    end else begin
      sat_v = shifted[OUT_W-1:0];
    end
`ifdef CNN_MAC_RELU_EN
    res_o = sat_v[OUT_W-1] ? '0 : sat_v;
`else
    res_o = sat_v;
`endif
  end

endmodule

// File: rtl/cnn_mac_accum.sv
// Accumulates one pixel's products plus bias, then rounds/saturates to the
// activation format. ReLU build option: CNN_MAC_RELU_EN.
module cnn_mac_accum
  import cnn_mac_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [OUT_W-1:0]  bias_dat,
  input  logic [PROD_W-1:0] prod_dat,
  input  logic              prod_vld,
  output logic              prod_rdy,
  output logic [OUT_W-1:0]  out_dat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output mac_state_t        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid never depends on ready; once out_vld rises, out_dat holds until the
  // transfer. prod_rdy is high only in ACCUM, out_vld only in OUT.

  mac_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [OUT_W-1:0]        out_dat_q, out_dat_d;
  logic signed [OUT_W-1:0] rs_res;

  cnn_mac_round_sat u_round_sat (
    .acc_i (acc_q),
    .res_o (rs_res)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    out_dat_d = out_dat_q;
    prod_rdy  = 1'b0;
    out_vld   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = acc_len;
          acc_d   = bias_to_acc(bias_dat);
          state_d = (acc_len != '0) ? ST_ACCUM : ST_ROUND;
        end
      end
      ST_ACCUM: begin
        prod_rdy = 1'b1;
        if (prod_vld) begin
          acc_d = acc_q + prod_to_acc(prod_dat);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        out_dat_d = rs_res;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      rem_q     <= '0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      out_dat_q <= out_dat_d;
    end
  end

  assign out_dat   = out_dat_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cnn_mac_accum.sv
// Randomized bench for cnn_mac_accum against an arithmetic reference model;
// follows the ReLU build when CNN_MAC_RELU_EN is defined.
module tb_cnn_mac_accum;
  import cnn_mac_pkg::*;

  logic              clk;
  logic              ap_rst;
  logic              start;
  logic [LEN_W-1:0]  acc_len;
  logic [OUT_W-1:0]  bias_dat;
  logic [PROD_W-1:0] prod_dat;
  logic              prod_vld;
  logic              prod_rdy;
  logic [OUT_W-1:0]  out_dat;
  logic              out_vld;
  logic              out_rdy;
  logic              busy;
  mac_state_t        state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  int prod_list[$];

  cnn_mac_accum dut (
    .ap_clk    (clk),
    .ap_rst    (ap_rst),
    .start     (start),
    .acc_len   (acc_len),
    .bias_dat  (bias_dat),
    .prod_dat  (prod_dat),
    .prod_vld  (prod_vld),
    .prod_rdy  (prod_rdy),
    .out_dat   (out_dat),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need end");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference: value = (bias*2^8 + sum) / 2^8, rounded half up, clamped.
  function automatic logic [OUT_W-1:0] ref_out(input longint total);
    longint n, q;
    logic [63:0] qv;
    n = total + 128;
    q = n / 256;
    if ((n % 256) != 0 && n < 0) q = q - 1;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
`ifdef CNN_MAC_RELU_EN
    if (q < 0) q = 0;
`endif
    qv = q;
    return qv[OUT_W-1:0];
  endfunction

  function automatic int rand_prod();
    return int'($urandom_range(0, 4194304)) - 2097152;
  endfunction

  // One accumulation: products come from prod_list. abort_at >= 0 resets the
  // DUT once that many products have been accepted.
  task automatic run_job(input logic [OUT_W-1:0] bias, input int stall_pct,
                         input int hold_cycles, input int abort_at);
    longint total;
    logic [OUT_W-1:0] held;
    int len, guard;
    bit got;
    len = prod_list.size();
    total = longint'($signed(bias)) * 256;
    foreach (prod_list[k]) total += longint'(prod_list[k]);
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    start    = 1'b1;
    acc_len  = LEN_W'(len);
    bias_dat = bias;
    out_rdy  = (hold_cycles == 0);
    exp_q.push_back(ref_out(total));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        ap_rst = 1'b1;
        #1;
        check_eq("rst_out_vld", 32'(out_vld), 0);
        check_eq("rst_prod_rdy", 32'(prod_rdy), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_out_dat", 32'(out_dat), 0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        prod_vld = 1'b0;
        @(posedge clk); #1;
        ap_rst = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      got = 1'b0;
      guard = 0;
      while (!got && guard < 100) begin
        prod_vld = ($urandom_range(0, 99) >= stall_pct) || (guard > 20);
        prod_dat = PROD_W'(prod_list[i]);
        @(negedge clk);
        if (i == 0 && guard == 0) check_eq("rdy_after_start", 32'(prod_rdy), 1);
        if (prod_vld && prod_rdy) got = 1'b1;
        @(posedge clk); #1;
        guard++;
      end
      if (!got) check_eq("prod_accept_timeout", 0, 1);
    end
    prod_vld = 1'b0;
    @(negedge clk);
    check_eq("lat_vld_early", 32'(out_vld), 0);
    if (len == 0) check_eq("len0_rdy1", 32'(prod_rdy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("lat_out_vld", 32'(out_vld), 1);
    if (len == 0) check_eq("len0_rdy2", 32'(prod_rdy), 0);
    if (hold_cycles > 0) begin
      held = out_dat;
      for (int h = 0; h < hold_cycles; h++) begin
        @(posedge clk); #1;
        start    = 1'b1;
        bias_dat = OUT_W'($urandom);
        @(negedge clk);
        check_eq("hold_vld", 32'(out_vld), 1);
        check_eq("hold_dat", 32'(out_dat), 32'(held));
        check_eq("hold_busy", 32'(busy), 1);
        check_eq("hold_prod_rdy", 32'(prod_rdy), 0);
      end
      @(posedge clk); #1;
      start   = 1'b0;
      out_rdy = 1'b1;
      @(negedge clk);
      check_eq("hs_vld", 32'(out_vld), 1);
    end
    if (exp_q.size() == 0) check_eq("scoreboard_empty", 1, 0);
    else check_eq("out_dat", 32'(out_dat), 32'(exp_q.pop_front()));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("vld_one_cycle", 32'(out_vld), 0);
    check_eq("idle_after", 32'(busy), 0);
  endtask

  initial begin
    int len;
    ap_rst = 1'b1; start = 1'b0; acc_len = '0; bias_dat = '0;
    prod_dat = '0; prod_vld = 1'b0; out_rdy = 1'b1;
    #1;
    check_eq("reset_out_vld", 32'(out_vld), 0);
    check_eq("reset_prod_rdy", 32'(prod_rdy), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_out_dat", 32'(out_dat), 0);
    repeat (3) @(posedge clk);
    #1 ap_rst = 1'b0;
    @(posedge clk); #1;

    // basic rounding: 640/256 = 2.5 -> 3
    prod_list = '{256, 512, -128};
    run_job(14'd0, 0, 0, -1);
    // bias only
    prod_list = {};
    run_job(14'd100, 0, 0, -1);
    // saturation both ways
    prod_list = '{2097152, 2097152};
    run_job(14'd0, 0, 0, -1);
    prod_list = '{-2097152, -2097152};
    run_job(14'd0, 0, 0, -1);
    // stalls and backpressure
    prod_list = {};
    for (int i = 0; i < 25; i++) prod_list.push_back(rand_prod() / 64);
    run_job(OUT_W'($urandom), 50, 5, -1);
    // reset mid-operation, then a fresh run
    prod_list = {};
    for (int i = 0; i < 25; i++) prod_list.push_back(rand_prod());
    run_job(14'd37, 0, 0, 10);
    prod_list = '{768};
    run_job(14'd0, 0, 0, -1);
    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      len = $urandom_range(0, 20);
      prod_list = {};
      for (int i = 0; i < len; i++)
        prod_list.push_back(($urandom_range(0, 1) != 0) ? rand_prod() / 512 : rand_prod());
      run_job(OUT_W'($urandom), $urandom_range(0, 60), $urandom_range(0, 3), -1);
    end
    // longest job at full magnitude
    prod_list = {};
    for (int i = 0; i < 255; i++) prod_list.push_back(-2097152);
    run_job(14'h2000, 10, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
